rect_frame_rx: RTL and testbench
================================

// Module: rect_frame_rx
// PURPOSE
//  Parametrised serial frame receiver for rectifier up-link data. Recovers bytes from a single
//  asynchronous line: start bit, 8 data bits LSB first, optional stop bit check.
//  Assembles HDR | CTRL | PAYLOAD | PAYLOAD copy | TRL frames.
//  Outputs the control field plus payload only when both payload copies and the trailer agree.
//  Adds per-frame error reporting, a stop-bit check and a configurable line polarity.
// PARAMETERS
//  CLKS_PER_BIT  2223    clk cycles per bit; bit counter runs 0..CLKS_PER_BIT-1
//  SAMPLE_PT     1111    bit-counter value at which the line is sampled (mid-bit)
//  LINE_INV      1       1: idle low, start high, data inverted; 0: standard UART levels
//  STOP_CHK      1       1: check one stop bit (idle level) after bit 8; 0: no check, no stop slot
//  HDR_BYTE      8'h55   frame header value
//  TRL_BYTE      8'hAA   frame trailer value
//  CTRL_W        4       low bits of the CTRL byte kept (1..8)
//  PAY_BYTES     2       payload bytes per copy (1..4); frame carries 2*PAY_BYTES payload bytes
//  TIMEOUT       11111   idle clks between bytes before a partial frame is dropped
// PORTS
//  clk         in   1                     system clock
//  rst         in   1                     asynchronous reset, active-high
//  rx_en       in   1                     start-detect gate (system "ready" condition)
//  rx_in       in   1                     serial line, asynchronous to clk
//  frame_valid out  1                     1-clk pulse: frame_data updated
//  frame_data  out  CTRL_W+8*PAY_BYTES    {ctrl[CTRL_W-1:0], pay0, pay1, ...}; pay0 = MSBs
//  frame_err   out  1                     1-clk pulse: frame rejected
//  err_code    out  3                     cause of last frame_err; held until the next one
// BEHAVIOUR
//  Reset: all outputs 0; both FSMs to idle; counters 0. A reset mid-frame discards all partial data.
//  rx_in passes a 2-flop synchroniser before any use. Latency figures below count from the
//  synchronised sample.
//  Byte FSM states:
//   IDLE : move to START when rx_en=1 and sync line = start level (LINE_INV); bit counter cleared.
//          rx_en=0 blocks new starts only; a byte already in progress completes.
//   START: at SAMPLE_PT, line != start level -> err 3'd1 (glitch), back to IDLE, no byte.
//          Otherwise continue.
//   DATA : 8 bit periods. At each SAMPLE_PT, shift in bit = line^LINE_INV at the MSB, shifting
//          right, so the first bit received ends up as the LSB.
//   STOP : (STOP_CHK=1) at SAMPLE_PT, line must be idle level (~LINE_INV). Otherwise err 3'd2
//          and the frame FSM returns to HDR.
//  Byte done:
//   - byte_done strobe fires at the stop sample; with STOP_CHK=0, at CLKS_PER_BIT-1 of bit 8.
//   - Byte FSM returns to IDLE the next clk, so back-to-back bytes are accepted.
//  Bit counter wraps CLKS_PER_BIT-1 -> 0 and advances the bit index.
//  Frame FSM (advances on byte_done only):
//   HDR  : byte==HDR_BYTE -> CTRL; any other byte is silently ignored (stay).
//   CTRL : store byte[CTRL_W-1:0] -> PAY.
//   PAY  : store 2*PAY_BYTES bytes into idx 0..2*PAY_BYTES-1 -> TRL.
//   TRL  : always back to HDR.
//          Copies equal and byte==TRL_BYTE -> load frame_data, frame_valid=1 one clk after byte_done.
//          Copy mismatch -> err 3'd3 (checked before trailer). Trailer mismatch -> err 3'd4.
//  Timeout:
//   - Gap counter clears on every byte_done and while the byte FSM is not IDLE.
//   - Counts otherwise. Saturates at TIMEOUT.
//   - On reaching TIMEOUT with the frame FSM not in HDR: frame FSM -> HDR, err 3'd5 once.
//  Errors:
//   - frame_err is a 1-clk pulse, asserted one clk after the cause; err_code is loaded at the same edge.
//   - A byte_done and a timeout in the same clk: byte_done wins, since the counter clears.
//  frame_data holds its value between frames; frame_valid and frame_err are never high together.
// TESTING  (CLKS_PER_BIT=16, SAMPLE_PT=8, TIMEOUT=200, other parameters default)
//  1 Frame 55 03 12 34 12 34 AA, back-to-back bytes -> single frame_valid, frame_data=20'h31234.
//  2 Frame 55 0F 12 34 12 35 AA -> frame_err, err_code=3'd3, frame_data unchanged, no frame_valid.
//  3 Frame 55 03 12 34 12 34 AB -> err_code=3'd4. Next, 00 55 03 56 78 56 78 AA -> frame_data=20'h35678.
//  4 Start-level pulse of 3 clks -> err_code=3'd1 and no byte. Byte with wrong stop level -> err_code=3'd2.
//  5 Send 55 03, then idle 201 clks -> err_code=3'd5 once. A following full frame is accepted.
//    With rx_en=0, a full frame yields no output.
//  6 rst pulse during payload byte 2, then a clean frame -> outputs 0 after reset; only the clean
//    frame is reported.

Source files
------------

// File: rtl/rect_frame_rx_if.sv
// Receiver-side bundle: serial line plus start gate in, frame results out.
// master = receiver, slave = the block feeding the line and consuming frames.
interface rect_frame_rx_if #(
  parameter int DATA_W = 20
);
  logic              rx_en;
  logic              rx_in;
  logic              frame_valid;
  logic [DATA_W-1:0] frame_data;
  logic              frame_err;
  logic [2:0]        err_code;

  modport master (
    input  rx_en, rx_in,
    output frame_valid, frame_data, frame_err, err_code
  );

  modport slave (
    output rx_en, rx_in,
    input  frame_valid, frame_data, frame_err, err_code
  );
endinterface

// File: rtl/rect_frame_rx.sv
// Serial frame receiver for rectifier up-link data: byte recovery from an async line,
// then HDR | CTRL | PAYLOAD | PAYLOAD copy | TRL assembly with per-frame error reporting.
module rect_frame_rx #(
  parameter int         CLKS_PER_BIT = 2223,
  parameter int         SAMPLE_PT    = 1111,
  parameter int         LINE_INV     = 1,
  parameter int         STOP_CHK     = 1,
  parameter logic [7:0] HDR_BYTE     = 8'h55,
  parameter logic [7:0] TRL_BYTE     = 8'hAA,
  parameter int         CTRL_W       = 4,
  parameter int         PAY_BYTES    = 2,
  parameter int         TIMEOUT      = 11111
) (
  input logic            clk,
  input logic            rst,
  rect_frame_rx_if.master bus
);
  localparam int   DATA_W    = CTRL_W + 8 * PAY_BYTES;
  localparam int   NPAY      = 2 * PAY_BYTES;
  localparam int   CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int   GAP_W     = $clog2(TIMEOUT + 1);
  localparam int   IDX_W     = $clog2(NPAY);
  localparam logic START_LVL = (LINE_INV != 0);
  localparam logic IDLE_LVL  = !START_LVL;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
  typedef enum logic [1:0] {F_HDR, F_CTRL, F_PAY, F_TRL} frame_state_t;

  logic [1:0]       sync_reg;
  logic             line;
  byte_state_t      byte_state_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;

  frame_state_t      frame_state_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [7:0]        pay_reg [NPAY];
  logic [IDX_W-1:0]  pay_idx_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              frame_valid_reg;
  logic              frame_err_reg;
  logic [2:0]        err_code_reg;
  logic [DATA_W-1:0] frame_data_reg;

  logic at_sample, at_end, byte_done, glitch_err, stop_err, timeout_hit;
  logic [PAY_BYTES-1:0]   copy_eq;
  logic [8*PAY_BYTES-1:0] pay_packed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= {2{IDLE_LVL}};
    else     sync_reg <= {sync_reg[0], bus.rx_in};
  end
  assign line = sync_reg[1];

  assign at_sample  = (bit_cnt_reg == CNT_W'(SAMPLE_PT));
  assign at_end     = (bit_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
  assign glitch_err = (byte_state_reg == B_START) && at_sample && (line != START_LVL);
  assign stop_err   = (STOP_CHK != 0) && (byte_state_reg == B_STOP) && at_sample && (line != IDLE_LVL);
  // Without a stop slot the byte completes at the end of the eighth data bit.
  assign byte_done  = (STOP_CHK != 0)
                    ? ((byte_state_reg == B_STOP) && at_sample && (line == IDLE_LVL))
                    : ((byte_state_reg == B_DATA) && at_end && (bit_idx_reg == 3'd7));
  assign timeout_hit = (byte_state_reg == B_IDLE) && !byte_done
                     && (gap_cnt_reg == GAP_W'(TIMEOUT - 1)) && (frame_state_reg != F_HDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_state_reg <= B_IDLE;
      bit_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
    end else begin
      case (byte_state_reg)
        B_IDLE: begin
          bit_cnt_reg <= '0;
          if (bus.rx_en && (line == START_LVL)) byte_state_reg <= B_START;
        end
        B_START: begin
          bit_cnt_reg <= at_end ? '0 : bit_cnt_reg + 1'b1;
          if (glitch_err) begin
            byte_state_reg <= B_IDLE;
          end else if (at_end) begin
            byte_state_reg <= B_DATA;
            bit_idx_reg    <= '0;
          end
        end
        B_DATA: begin
          bit_cnt_reg <= at_end ? '0 : bit_cnt_reg + 1'b1;
          if (at_sample) shift_reg <= {line ^ START_LVL, shift_reg[7:1]};
          if (at_end) begin
            if (bit_idx_reg == 3'd7) begin
              if (STOP_CHK != 0) byte_state_reg <= B_STOP;
              else               byte_state_reg <= B_IDLE;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        B_STOP: begin
          bit_cnt_reg <= at_end ? '0 : bit_cnt_reg + 1'b1;
          // Leave at the stop sample so a back-to-back start edge is not missed.
          if (at_sample) byte_state_reg <= B_IDLE;
        end
        default: byte_state_reg <= B_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < PAY_BYTES; gi++) begin : g_pay
    assign copy_eq[gi] = (pay_reg[gi] == pay_reg[gi + PAY_BYTES]);
    assign pay_packed[8*(PAY_BYTES-gi)-1 -: 8] = pay_reg[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_state_reg <= F_HDR;
      ctrl_reg        <= '0;
      pay_idx_reg     <= '0;
      gap_cnt_reg     <= '0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      err_code_reg    <= '0;
      frame_data_reg  <= '0;
      for (int i = 0; i < NPAY; i++) pay_reg[i] <= '0;
    end else begin
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;

      if (byte_done || (byte_state_reg != B_IDLE)) gap_cnt_reg <= '0;
      else if (gap_cnt_reg != GAP_W'(TIMEOUT))     gap_cnt_reg <= gap_cnt_reg + 1'b1;

      if (glitch_err) begin
        frame_err_reg <= 1'b1;
        err_code_reg  <= 3'd1;
      end
      if (stop_err) begin
        frame_err_reg   <= 1'b1;
        err_code_reg    <= 3'd2;
        frame_state_reg <= F_HDR;
      end
      if (timeout_hit) begin
        frame_err_reg   <= 1'b1;
        err_code_reg    <= 3'd5;
        frame_state_reg <= F_HDR;
      end

      if (byte_done) begin
        case (frame_state_reg)
          F_HDR: if (shift_reg == HDR_BYTE) frame_state_reg <= F_CTRL;
          F_CTRL: begin
            ctrl_reg        <= shift_reg[CTRL_W-1:0];
            pay_idx_reg     <= '0;
            frame_state_reg <= F_PAY;
          end
          F_PAY: begin
            pay_reg[pay_idx_reg] <= shift_reg;
            if (pay_idx_reg == IDX_W'(NPAY - 1)) frame_state_reg <= F_TRL;
            else                                 pay_idx_reg     <= pay_idx_reg + 1'b1;
          end
          default: begin
            frame_state_reg <= F_HDR;
            // Copy disagreement takes precedence over a bad trailer.
            if (!(&copy_eq)) begin
              frame_err_reg <= 1'b1;
              err_code_reg  <= 3'd3;
            end else if (shift_reg != TRL_BYTE) begin
              frame_err_reg <= 1'b1;
              err_code_reg  <= 3'd4;
            end else begin
              frame_valid_reg <= 1'b1;
              frame_data_reg  <= {ctrl_reg, pay_packed};
            end
          end
        endcase
      end
    end
  end

  assign bus.frame_valid = frame_valid_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.err_code    = err_code_reg;
  assign bus.frame_data  = frame_data_reg;
endmodule

// File: tb/tb_rect_frame_rx.sv
// Bench for rect_frame_rx: directed frames plus randomized byte streams, checked every cycle
// against a byte-level frame model that predicts the ordered list of valid/error pulses.
module tb_rect_frame_rx;
  localparam int CPB = 16;
  localparam int TMO = 200;
  localparam int DW  = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rect_frame_rx_if #(.DATA_W(DW)) bus ();

  rect_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .SAMPLE_PT   (8),
    .TIMEOUT     (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          is_err;
    logic [2:0]  code;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_valid  = 0;
  int            n_err    = 0;
  logic [DW-1:0] exp_data = '0;
  logic [2:0]    exp_code = '0;

  int         m_state = 0;
  logic [3:0] m_ctrl;
  logic [7:0] m_pay [4];
  int         m_idx;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic push(input bit is_err, input logic [2:0] code, input logic [DW-1:0] d);
    ev_t e;
    e.is_err = is_err;
    e.code   = code;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  // Frame rules applied to one received byte.
  task automatic model_byte(input logic [7:0] b, input bit bad_stop);
    if (bad_stop) begin
      push(1'b1, 3'd2, '0);
      m_state = 0;
      return;
    end
    case (m_state)
      0: if (b == 8'h55) m_state = 1;
      1: begin
        m_ctrl  = b[3:0];
        m_idx   = 0;
        m_state = 2;
      end
      2: begin
        m_pay[m_idx] = b;
        m_idx++;
        if (m_idx == 4) m_state = 3;
      end
      default: begin
        m_state = 0;
        if ({m_pay[0], m_pay[1]} != {m_pay[2], m_pay[3]}) push(1'b1, 3'd3, '0);
        else if (b != 8'hAA)                              push(1'b1, 3'd4, '0);
        else push(1'b0, 3'd0, {m_ctrl, m_pay[0], m_pay[1]});
      end
    endcase
  endtask

  // Pulses are matched in order against the model; held outputs are checked every cycle.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (bus.frame_valid || bus.frame_err) begin
        chk(!(bus.frame_valid && bus.frame_err), "valid_err_exclusive",
            32'({bus.frame_valid, bus.frame_err}), 32'd0);
        if (bus.frame_valid) n_valid++;
        if (bus.frame_err)   n_err++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pulse", 32'({bus.frame_valid, bus.frame_err}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err) begin
            chk(bus.frame_err, "pulse_kind_err", 32'(bus.frame_valid), 32'd0);
            exp_code = e.code;
          end else begin
            chk(bus.frame_valid, "pulse_kind_valid", 32'(bus.err_code), 32'd0);
            exp_data = e.data;
          end
        end
      end
      chk(bus.frame_data == exp_data, "frame_data", 32'(bus.frame_data), 32'(exp_data));
      chk(bus.err_code == exp_code, "err_code", 32'(bus.err_code), 32'(exp_code));
    end
  end

  task automatic hold(input logic v, input int n);
    bus.rx_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Inverted line: idle low, start high, data bits inverted.
  task automatic drive_byte(input logic [7:0] b, input bit bad_stop);
    hold(1'b1, CPB);
    for (int i = 0; i < 8; i++) hold(~b[i], CPB);
    if (bad_stop) begin
      bus.rx_en = 1'b0;
      hold(1'b1, CPB);
      hold(1'b0, 4);
      bus.rx_en = 1'b1;
    end else begin
      hold(1'b0, CPB);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    model_byte(b, bad_stop);
    drive_byte(b, bad_stop);
  endtask

  task automatic send_frame(input logic [55:0] f);
    for (int i = 6; i >= 0; i--) send_byte(f[8*i +: 8], 1'b0);
  endtask

  task automatic gap(input int n);
    if (n >= TMO && m_state != 0) begin
      push(1'b1, 3'd5, '0);
      m_state = 0;
    end
    hold(1'b0, n);
  endtask

  task automatic drained(input string name);
    repeat (3) @(posedge clk);
    #1;
    chk(exp_q.size() == 0, name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    bus.rx_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(bus.frame_valid == 1'b0, "rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    chk(bus.frame_err == 1'b0, "rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk(bus.frame_data == '0, "rst_frame_data", 32'(bus.frame_data), 32'd0);
    chk(bus.err_code == 3'd0, "rst_err_code", 32'(bus.err_code), 32'd0);
    exp_q.delete();
    exp_data = '0;
    exp_code = '0;
    m_state  = 0;
    rst = 1'b0;
    hold(1'b0, 20);
  endtask

  initial begin
    int v0, e0, r, long_pos, bad_pos;
    logic [7:0] fr [7];

    bus.rx_en = 1'b1;
    bus.rx_in = 1'b0;
    do_reset();

    // Clean back-to-back frame.
    v0 = n_valid;
    send_frame(56'h55_03_12_34_12_34_AA);
    drained("t1_drain");
    chk(bus.frame_data == 20'h31234, "t1_data", 32'(bus.frame_data), 32'h31234);
    chk(n_valid == v0 + 1, "t1_valid_count", 32'(n_valid - v0), 32'd1);

    // Payload copy mismatch.
    v0 = n_valid;
    send_frame(56'h55_0F_12_34_12_35_AA);
    drained("t2_drain");
    chk(bus.err_code == 3'd3, "t2_code", 32'(bus.err_code), 32'd3);
    chk(bus.frame_data == 20'h31234, "t2_data_held", 32'(bus.frame_data), 32'h31234);
    chk(n_valid == v0, "t2_no_valid", 32'(n_valid - v0), 32'd0);

    // Bad trailer, then junk byte and a good frame.
    send_frame(56'h55_03_12_34_12_34_AB);
    drained("t3a_drain");
    chk(bus.err_code == 3'd4, "t3_code", 32'(bus.err_code), 32'd4);
    send_byte(8'h00, 1'b0);
    send_frame(56'h55_03_56_78_56_78_AA);
    drained("t3b_drain");
    chk(bus.frame_data == 20'h35678, "t3_data", 32'(bus.frame_data), 32'h35678);

    // Short start-level glitch, then a byte with the wrong stop level.
    push(1'b1, 3'd1, '0);
    hold(1'b1, 3);
    hold(1'b0, 40);
    drained("t4a_drain");
    chk(bus.err_code == 3'd1, "t4_glitch_code", 32'(bus.err_code), 32'd1);
    send_byte(8'h55, 1'b1);
    drained("t4b_drain");
    chk(bus.err_code == 3'd2, "t4_stop_code", 32'(bus.err_code), 32'd2);

    // Inter-byte timeout, recovery, then a frame with the start gate closed.
    e0 = n_err;
    send_byte(8'h55, 1'b0);
    send_byte(8'h03, 1'b0);
    gap(201);
    drained("t5a_drain");
    chk(bus.err_code == 3'd5, "t5_code", 32'(bus.err_code), 32'd5);
    chk(n_err == e0 + 1, "t5_err_once", 32'(n_err - e0), 32'd1);
    send_frame(56'h55_03_9A_BC_9A_BC_AA);
    drained("t5b_drain");
    chk(bus.frame_data == 20'h39ABC, "t5_data", 32'(bus.frame_data), 32'h39ABC);
    v0 = n_valid;
    e0 = n_err;
    bus.rx_en = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      fr[0] = 8'h55; fr[1] = 8'h03; fr[2] = 8'h11; fr[3] = 8'h22;
      fr[4] = 8'h11; fr[5] = 8'h22; fr[6] = 8'hAA;
      drive_byte(fr[6 - i], 1'b0);
    end
    hold(1'b0, 20);
    bus.rx_en = 1'b1;
    drained("t5c_drain");
    chk((n_valid == v0) && (n_err == e0), "t5_gated_silent", 32'(n_valid - v0 + n_err - e0), 32'd0);

    // Reset in the middle of the second payload byte.
    send_byte(8'h55, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h12, 1'b0);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b1, 5);
    do_reset();
    v0 = n_valid;
    send_frame(56'h55_05_AB_CD_AB_CD_AA);
    drained("t6_drain");
    chk(bus.frame_data == 20'h5ABCD, "t6_data", 32'(bus.frame_data), 32'h5ABCD);
    chk(n_valid == v0 + 1, "t6_valid_count", 32'(n_valid - v0), 32'd1);

    // Randomized frames with occasional corruption, junk, timeouts and bad stop bits.
    for (int f = 0; f < 20; f++) begin
      fr[0] = 8'h55;
      fr[1] = 8'($urandom);
      fr[2] = 8'($urandom);
      fr[3] = 8'($urandom);
      fr[4] = fr[2];
      fr[5] = fr[3];
      fr[6] = 8'hAA;
      r = $urandom_range(0, 9);
      if (r == 0) fr[4] = fr[4] ^ (8'h01 << $urandom_range(0, 7));
      if (r == 1) fr[6] = fr[6] ^ 8'h10;
      if (r == 2) send_byte(8'($urandom), 1'b0);
      long_pos = (r == 3) ? $urandom_range(1, 6) : 99;
      bad_pos  = (r == 4) ? $urandom_range(0, 6) : 99;
      for (int i = 0; i < 7; i++) begin
        if (i == long_pos) gap($urandom_range(TMO + 5, TMO + 40));
        else if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 60));
        send_byte(fr[i], i == bad_pos);
      end
      gap($urandom_range(5, 30));
    end
    drained("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
